bin_bcd_display: RTL and testbench



---
 rtl/bin_bcd_display_pkg.sv | 21 ++
 rtl/bin_bcd_display_if.sv | 12 +
 rtl/bin_bcd_display_bcd_to_seg.sv | 19 +
 rtl/bin_bcd_display.sv | 138 +++++++++++++
 tb/tb_bin_bcd_display.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/bin_bcd_display_pkg.sv
// Shared types and constants for the binary-to-BCD seven-segment display.
// Holds the FSM state enum, segment codes and the digit-to-segment table.
package bin_bcd_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [6:0]  SEG_BLANK   = 7'h7F;
    localparam logic [6:0]  SEG_DASH    = 7'h3F;
    localparam logic [31:0] MAX_DISPLAY = 32'd999999;

    // Active-low a..g (bit0=a), indexed by decimal digit
    localparam logic [0:9][6:0] SEG_LUT = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/bin_bcd_display_if.sv
// Valid/ready input channel carrying the binary value to display.
// master: producer drives in_value/in_valid; slave: display drives in_ready.
interface bin_bcd_display_if #(
    parameter int WIDTH = 20
);
    logic [WIDTH-1:0] in_value;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_value, output in_valid, input in_ready);
    modport slave  (input in_value, input in_valid, output in_ready);
endinterface

// File: rtl/bin_bcd_display_bcd_to_seg.sv
// One BCD digit to active-low seven-segment code, with dash/blank override.
// Ports: digit (4b BCD), blank, dash -> seg (7b, bit0=a .. bit6=g).
module bcd_to_seg
    import bin_bcd_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (!blank && digit < 4'd10) begin
            seg = SEG_LUT[digit];
        end
    end
endmodule

// File: rtl/bin_bcd_display.sv
// Iterative double-dabble converter feeding six registered 7-seg digits.
// Ports: clk, rst (async, active-low), in_if (slave), out_valid, overflow, seg0..seg5.
module bin_bcd_display
    import bin_bcd_display_pkg::*;
#(
    parameter int WIDTH    = 20,
    parameter int DIGITS   = 6,
    parameter int BLANK_LZ = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    bin_bcd_display_if.slave       in_if,
    output logic                   out_valid,
    output logic                   overflow,
    output logic [6:0]             seg0,
    output logic [6:0]             seg1,
    output logic [6:0]             seg2,
    output logic [6:0]             seg3,
    output logic [6:0]             seg4,
    output logic [6:0]             seg5
);
    localparam int CW = $clog2(WIDTH);
    localparam int BW = DIGITS * 4;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic              overflow_q, overflow_d;
    logic              out_valid_q, out_valid_d;
    logic [6:0]        seg_q [DIGITS];
    logic [6:0]        seg_d [DIGITS];
    logic [6:0]        seg_c [DIGITS];
    logic [BW-1:0]     bcd_adj;
    logic [DIGITS-1:0] blank;

    assign in_if.in_ready = (state_q == IDLE);

    // Pre-shift correction: nibbles >=5 would carry past 9 after doubling
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // A digit blanks only while it and everything above it is zero
    always_comb begin
        logic zero_hi;
        zero_hi = 1'b1;
        blank   = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_hi  = zero_hi && (bcd_q[4*i +: 4] == 4'd0);
            blank[i] = (BLANK_LZ != 0) && zero_hi;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        bcd_to_seg u_seg (
            .digit (bcd_q[4*g +: 4]),
            .blank (blank[g]),
            .dash  (ovf_pend_q),
            .seg   (seg_c[g])
        );
    end

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        ovf_pend_d  = ovf_pend_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        seg_d       = seg_q;
        unique case (state_q)
            IDLE: begin
                if (in_if.in_valid) begin
                    bin_d      = in_if.in_value;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = 32'(in_if.in_value) > MAX_DISPLAY;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                seg_d       = seg_c;
                overflow_d  = ovf_pend_q;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            ovf_pend_q  <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                seg_q[i] <= SEG_BLANK;
            end
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            ovf_pend_q  <= ovf_pend_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            seg_q       <= seg_d;
        end
    end

    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign seg0      = seg_q[0];
    assign seg1      = seg_q[1];
    assign seg2      = seg_q[2];
    assign seg3      = seg_q[3];
    assign seg4      = seg_q[4];
    assign seg5      = seg_q[5];
endmodule

// File: tb/tb_bin_bcd_display.sv
// Scoreboard bench for bin_bcd_display: two instances (blanking on/off)
// share stimulus; a decimal reference model predicts each display update.
module tb_bin_bcd_display;
    localparam int W = 20;

    typedef struct {
        logic [41:0] seg;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bin_bcd_display_if #(.WIDTH(W)) bus0 ();
    bin_bcd_display_if #(.WIDTH(W)) bus1 ();
    assign bus1.in_value = bus0.in_value;
    assign bus1.in_valid = bus0.in_valid;

    logic       ov0, of0, ov1, of1;
    logic [6:0] a0, a1, a2, a3, a4, a5;
    logic [6:0] b0, b1, b2, b3, b4, b5;

    bin_bcd_display #(.WIDTH(W), .DIGITS(6), .BLANK_LZ(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_if(bus0),
        .out_valid(ov0), .overflow(of0),
        .seg0(a0), .seg1(a1), .seg2(a2),
        .seg3(a3), .seg4(a4), .seg5(a5)
    );

    bin_bcd_display #(.WIDTH(W), .DIGITS(6), .BLANK_LZ(0)) u_dut1 (
        .clk(clk), .rst(rst), .in_if(bus1),
        .out_valid(ov1), .overflow(of1),
        .seg0(b0), .seg1(b1), .seg2(b2),
        .seg3(b3), .seg4(b4), .seg5(b5)
    );

    logic [6:0] lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   last_acc = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(int v, bit blz, int acc);
        exp_t m;
        int   p;
        p     = 1;
        m.acc = acc;
        m.ovf = (v > 999999);
        m.seg = '0;
        for (int i = 0; i < 6; i++) begin
            if (m.ovf)
                m.seg[7*i +: 7] = 7'h3F;
            else if (blz && i > 0 && (v / p) == 0)
                m.seg[7*i +: 7] = 7'h7F;
            else
                m.seg[7*i +: 7] = lut[(v / p) % 10];
            p = p * 10;
        end
        return m;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst && ov0) begin
            if (q0.size() == 0) begin
                chk("blz1_unexpected_out_valid", 1, 0);
            end else begin
                e = q0.pop_front();
                chk("blz1_seg", {a5, a4, a3, a2, a1, a0}, e.seg);
                chk("blz1_overflow", of0, e.ovf);
                chk("blz1_latency", cyc - e.acc, W + 1);
            end
        end
        if (rst && ov1) begin
            if (q1.size() == 0) begin
                chk("blz0_unexpected_out_valid", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("blz0_seg", {b5, b4, b3, b2, b1, b0}, e.seg);
                chk("blz0_overflow", of1, e.ovf);
                chk("blz0_latency", cyc - e.acc, W + 1);
            end
        end
    end

    task automatic send(int v, bit gap);
        int t;
        bus0.in_valid = 1'b1;
        bus0.in_value = v[W-1:0];
        t = 0;
        while (!bus0.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus0.in_ready) begin
            chk("accept_timeout", 0, 1);
            bus0.in_valid = 1'b0;
            return;
        end
        q0.push_back(model(v, 1'b1, cyc + 1));
        q1.push_back(model(v, 1'b0, cyc + 1));
        if (gap) chk("accept_gap", cyc + 1 - last_acc, W + 2);
        last_acc = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        bus0.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain_pending", q0.size() + q1.size(), 0);
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, "_seg_blz1"}, {a5, a4, a3, a2, a1, a0}, {6{7'h7F}});
        chk({tag, "_seg_blz0"}, {b5, b4, b3, b2, b1, b0}, {6{7'h7F}});
        chk({tag, "_overflow"}, {of0, of1}, 2'b00);
        chk({tag, "_out_valid"}, {ov0, ov1}, 2'b00);
        chk({tag, "_in_ready"}, {bus0.in_ready, bus1.in_ready}, 2'b11);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int v;
        bus0.in_valid = 1'b0;
        bus0.in_value = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b1;
        @(negedge clk);

        send(1234, 1'b0);
        drain();
        send(0, 1'b0);
        drain();
        send(999999, 1'b0);
        send(1000000, 1'b1);
        drain();

        send(42, 1'b0);
        chk("busy_in_ready", bus0.in_ready, 0);
        send(77, 1'b1);
        drain();

        send(5678, 1'b0);
        repeat (9) @(posedge clk);
        #2 rst = 1'b0;
        q0.delete();
        q1.delete();
        #1 chk_reset_state("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(5, 1'b0);
        drain();

        send(10, 1'b0);
        send(20, 1'b1);
        send(30, 1'b1);
        drain();

        for (int i = 0; i < 24; i++) begin
            case (i % 3)
                0:       v = int'($urandom_range(0, 1048575));
                1:       v = int'($urandom_range(0, 999));
                default: v = int'($urandom_range(990000, 1010000));
            endcase
            send(v, i > 0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
